// File: rtl/cfg_reg_pkg.sv
// Shared definitions for the watchdog configuration bank: register offsets,
// lock-FSM state type and STATUS / SERVICE bit positions.
package cfg_reg_pkg;

    // Channel register select (low two address bits when ABUS MSB is 0)
    localparam int unsigned SelFwlen   = 0;
    localparam int unsigned SelSwlen   = 1;
    localparam int unsigned SelService = 2;
    localparam int unsigned SelRstLmt  = 3;

    // Global register offsets (ABUS MSB is 1)
    localparam int unsigned GlbOffKey    = 0;
    localparam int unsigned GlbOffStatus = 1;

    // STATUS register bit positions
    localparam int unsigned StatusLockedBit = 0;
    localparam int unsigned StatusWerrBit   = 1;

    // SERVICE register bit positions
    localparam int unsigned SrvcFlstatLsb = 0;
    localparam int unsigned SrvcPulseBit  = 3;
    localparam int unsigned SrvcInitBit   = 4;

    // Lock sequencer states
    typedef enum logic [1:0] {
        StUnlocked = 2'd0,
        StLocked   = 2'd1,
        StKey1     = 2'd2
    } lock_state_e;

endpackage

// File: rtl/cfg_lock_fsm.sv
// Key-sequence write lock for the watchdog configuration bank.
// Only KEY writes advance it, except in KEY1 where any write aborts the unlock.
module cfg_lock_fsm
    import cfg_reg_pkg::*;
#(
    parameter int unsigned DW          = 8,
    parameter bit          LOCK_AT_RST = 1'b0,
    parameter logic [7:0]  LOCK_KEY    = 8'hA5,
    parameter logic [7:0]  UNLK_KEY1   = 8'h55,
    parameter logic [7:0]  UNLK_KEY2   = 8'hAA
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          wren_i,
    input  logic          key_wr_i,
    input  logic [DW-1:0] wdata_i,
    output logic          locked_o,
    output logic          wr_allow_o,
    output logic          key_err_o
);

    localparam lock_state_e RstState = LOCK_AT_RST ? StLocked : StUnlocked;

    lock_state_e state_q, state_d;
    logic        locked_q;

    // Next-state decode and same-cycle key error pulse
    always_comb begin
        state_d   = state_q;
        key_err_o = 1'b0;
        case (state_q)
            StUnlocked: begin
                if (key_wr_i && (wdata_i == DW'(LOCK_KEY))) begin
                    state_d = StLocked;
                end
            end
            StLocked: begin
                if (key_wr_i) begin
                    if (wdata_i == DW'(UNLK_KEY1)) begin
                        state_d = StKey1;
                    end else begin
                        key_err_o = 1'b1;
                    end
                end
            end
            StKey1: begin
                // The second key must be the very next write of any kind
                if (wren_i) begin
                    if (key_wr_i && (wdata_i == DW'(UNLK_KEY2))) begin
                        state_d = StUnlocked;
                    end else begin
                        state_d   = StLocked;
                        key_err_o = 1'b1;
                    end
                end
            end
            default: state_d = RstState;
        endcase
    end

    // State register with registered lock flag
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= RstState;
            locked_q <= LOCK_AT_RST;
        end else begin
            state_q  <= state_d;
            locked_q <= (state_d != StUnlocked);
        end
    end

    assign locked_o   = locked_q;
    assign wr_allow_o = ~locked_q;

endmodule

// File: rtl/watchdog_config_bank.sv
// Multi-channel configuration register bank for the windowed watchdog.
// Optional feature: define CFG_PARITY_EN to store an even-parity bit per register
// and raise a sticky PERR on any mismatch.
module watchdog_config_bank
    import cfg_reg_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned DW          = 8,
    parameter bit          LOCK_AT_RST = 1'b0,
    parameter logic [7:0]  LOCK_KEY    = 8'hA5,
    parameter logic [7:0]  UNLK_KEY1   = 8'h55,
    parameter logic [7:0]  UNLK_KEY2   = 8'hAA,
    localparam int unsigned CW         = $clog2(NUM_CH),
    localparam int unsigned AW         = CW + 3
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 WREN,
    input  logic                 REN,
    input  logic [AW-1:0]        ABUS,
    input  logic [DW-1:0]        DBUS,
    output logic [DW-1:0]        RDATA,
    output logic                 RVALID,
    output logic [NUM_CH*DW-1:0] FWLEN,
    output logic [NUM_CH*DW-1:0] SWLEN,
    output logic [NUM_CH*DW-1:0] RST_LMT,
    output logic [NUM_CH-1:0]    WDSRVC,
    output logic [NUM_CH-1:0]    INIT,
    output logic [NUM_CH*3-1:0]  FLSTAT,
    output logic                 LOCKED,
    output logic                 WERR,
    output logic                 PERR
);

    // Address decode
    logic          a_glb;
    logic [CW-1:0] a_ch;
    logic [1:0]    a_sel;
    logic [AW-2:0] a_off;

    assign a_glb = ABUS[AW-1];
    assign a_ch  = ABUS[AW-2:2];
    assign a_sel = ABUS[1:0];
    assign a_off = ABUS[AW-2:0];

    logic ch_wr, key_wr, stat_wr;

    assign ch_wr   = WREN & ~a_glb;
    assign key_wr  = WREN & a_glb & (a_off == (AW-1)'(GlbOffKey));
    assign stat_wr = WREN & a_glb & (a_off == (AW-1)'(GlbOffStatus));

    logic wr_allow, key_err;

    cfg_lock_fsm #(
        .DW          (DW),
        .LOCK_AT_RST (LOCK_AT_RST),
        .LOCK_KEY    (LOCK_KEY),
        .UNLK_KEY1   (UNLK_KEY1),
        .UNLK_KEY2   (UNLK_KEY2)
    ) u_lock (
        .clk_i      (CLK),
        .rst_ni     (RST_N),
        .wren_i     (WREN),
        .key_wr_i   (key_wr),
        .wdata_i    (DBUS),
        .locked_o   (LOCKED),
        .wr_allow_o (wr_allow),
        .key_err_o  (key_err)
    );

    // Register storage
    logic [DW-1:0]     fwlen_q   [NUM_CH];
    logic [DW-1:0]     fwlen_d   [NUM_CH];
    logic [DW-1:0]     swlen_q   [NUM_CH];
    logic [DW-1:0]     swlen_d   [NUM_CH];
    logic [DW-1:0]     rst_lmt_q [NUM_CH];
    logic [DW-1:0]     rst_lmt_d [NUM_CH];
    logic [2:0]        flstat_q  [NUM_CH];
    logic [2:0]        flstat_d  [NUM_CH];
    logic [NUM_CH-1:0] init_q, init_d;
    logic [NUM_CH-1:0] srvc_q, srvc_d;
    logic              werr_q, werr_d;
    logic [DW-1:0]     rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic [DW-1:0]     rd_val;

    // Channel register updates and service pulse request
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            fwlen_d[i]   = fwlen_q[i];
            swlen_d[i]   = swlen_q[i];
            rst_lmt_d[i] = rst_lmt_q[i];
            flstat_d[i]  = flstat_q[i];
            init_d[i]    = init_q[i];
            srvc_d[i]    = 1'b0;
            if (ch_wr && wr_allow && (a_ch == CW'(i))) begin
                unique case (a_sel)
                    2'(SelFwlen):   fwlen_d[i]   = DBUS;
                    2'(SelSwlen):   swlen_d[i]   = DBUS;
                    2'(SelService): begin
                        flstat_d[i] = DBUS[SrvcFlstatLsb +: 3];
                        init_d[i]   = DBUS[SrvcInitBit];
                        srvc_d[i]   = DBUS[SrvcPulseBit];
                    end
                    2'(SelRstLmt):  rst_lmt_d[i] = DBUS;
                endcase
            end
        end
    end

    // Sticky write error: a new error wins over a same-cycle clear
    always_comb begin
        werr_d = werr_q;
        if (stat_wr && DBUS[StatusWerrBit]) begin
            werr_d = 1'b0;
        end
        if (key_err || (ch_wr && !wr_allow)) begin
            werr_d = 1'b1;
        end
    end

    // Readback mux sampled on REN; reflects pre-write contents
    always_comb begin
        rd_val = '0;
        if (!a_glb) begin
            unique case (a_sel)
                2'(SelFwlen):   rd_val = fwlen_q[a_ch];
                2'(SelSwlen):   rd_val = swlen_q[a_ch];
                2'(SelService): begin
                    rd_val[SrvcFlstatLsb +: 3] = flstat_q[a_ch];
                    rd_val[SrvcInitBit]        = init_q[a_ch];
                end
                2'(SelRstLmt):  rd_val = rst_lmt_q[a_ch];
            endcase
        end else if (a_off == (AW-1)'(GlbOffStatus)) begin
            rd_val[StatusLockedBit] = LOCKED;
            rd_val[StatusWerrBit]   = werr_q;
        end
        rdata_d  = REN ? rd_val : rdata_q;
        rvalid_d = REN;
    end

    // State registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NUM_CH; i++) begin
                fwlen_q[i]   <= '0;
                swlen_q[i]   <= '0;
                rst_lmt_q[i] <= '0;
                flstat_q[i]  <= '0;
            end
            init_q   <= '0;
            srvc_q   <= '0;
            werr_q   <= 1'b0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                fwlen_q[i]   <= fwlen_d[i];
                swlen_q[i]   <= swlen_d[i];
                rst_lmt_q[i] <= rst_lmt_d[i];
                flstat_q[i]  <= flstat_d[i];
            end
            init_q   <= init_d;
            srvc_q   <= srvc_d;
            werr_q   <= werr_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    // Output packing, channel 0 at the LSBs
    for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
        assign FWLEN[g*DW +: DW]   = fwlen_q[g];
        assign SWLEN[g*DW +: DW]   = swlen_q[g];
        assign RST_LMT[g*DW +: DW] = rst_lmt_q[g];
        assign FLSTAT[g*3 +: 3]    = flstat_q[g];
    end

    assign INIT   = init_q;
    assign WDSRVC = srvc_q;
    assign WERR   = werr_q;
    assign RDATA  = rdata_q;
    assign RVALID = rvalid_q;

`ifdef CFG_PARITY_EN
    logic [NUM_CH-1:0] fw_par_q, sw_par_q, rl_par_q, sv_par_q;
    logic              perr_q, par_bad;

    // Recompute parity of every stored register and compare with the stored bit
    always_comb begin
        par_bad = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            par_bad = par_bad | ((^fwlen_q[i]) ^ fw_par_q[i]);
            par_bad = par_bad | ((^swlen_q[i]) ^ sw_par_q[i]);
            par_bad = par_bad | ((^rst_lmt_q[i]) ^ rl_par_q[i]);
            par_bad = par_bad | ((^{init_q[i], flstat_q[i]}) ^ sv_par_q[i]);
        end
    end

    // Parity bits written alongside the data; PERR clears only on reset
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            fw_par_q <= '0;
            sw_par_q <= '0;
            rl_par_q <= '0;
            sv_par_q <= '0;
            perr_q   <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                fw_par_q[i] <= ^fwlen_d[i];
                sw_par_q[i] <= ^swlen_d[i];
                rl_par_q[i] <= ^rst_lmt_d[i];
                sv_par_q[i] <= ^{init_d[i], flstat_d[i]};
            end
            perr_q <= perr_q | par_bad;
        end
    end

    assign PERR = perr_q;
`else
    assign PERR = 1'b0;
`endif

endmodule
